// File: rtl/ethernet_decapsulation.sv
// ethernet_decapsulation: GMII RX framer that strips preamble/header/pad, filters DA and flags errors.
// Optional CRC-32 FCS check is compiled in when ETH_RX_CRC_CHECK_EN is defined.
module ethernet_decapsulation #(
   parameter logic [47:0] LOCAL_MAC_ADDR = 48'h023528fbdd66,
   parameter int          MAX_PAYLOAD    = 1500,
   parameter int          MIN_PAYLOAD    = 46
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_last,
   output logic [47:0] src_mac,
   output logic [15:0] frame_len,
   output logic        frame_done,
   output logic        frame_ok,
   output logic        err_crc,
   output logic        err_len,
   output logic        err_gmii,
   output logic        err_trunc
);
   typedef enum logic [3:0] {IDLE, PREAMBLE, DEST_MAC, SRC_MAC, LEN, PAYLOAD, PAD, FCS, WAIT_END, DROP} state_t;
   localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
   localparam logic [10:0] MIN_LEN = 11'(MIN_PAYLOAD);
   state_t      state;
   logic [10:0] cnt;
   logic [10:0] cnt_inc;
   logic [39:0] dst;
   logic [47:0] dst_rx;
   logic [15:0] len_rx;
   logic        dst_hit;
   logic        dst_ok;
   logic        in_frame;
   logic        sfd;
   assign cnt_inc  = (cnt == 11'h7ff) ? cnt : cnt + 11'd1;
   assign dst_rx   = {dst, gmii_rxd};
   assign dst_hit  = (dst_rx == LOCAL_MAC_ADDR) || (&dst_rx);
   assign len_rx   = {frame_len[15:8], gmii_rxd};
   assign sfd      = (state == PREAMBLE) && gmii_rx_dv && (gmii_rxd == 8'hd5);
   // states in which losing rx_dv means the frame was cut short
   assign in_frame = state inside {DEST_MAC, SRC_MAC, LEN, PAYLOAD, PAD, FCS};
`ifdef ETH_RX_CRC_CHECK_EN
   logic [31:0] crc;
   logic [31:0] crc_nx;
   always_comb begin
      crc_nx = crc ^ {24'd0, gmii_rxd};
      for (int i = 0; i < 8; i++) crc_nx = crc_nx[0] ? (crc_nx >> 1) ^ 32'hedb88320 : crc_nx >> 1;
   end
   // residue of a reflected CRC-32 run across its own FCS
   always_ff @(posedge clk) begin
      if (rst) begin
         crc     <= '1;
         err_crc <= 1'b0;
      end else begin
         crc     <= (state == PREAMBLE) ? '1 : (in_frame && gmii_rx_dv) ? crc_nx : crc;
         err_crc <= sfd ? 1'b0 : err_crc | ((state == FCS) && (cnt == 11'd3) && gmii_rx_dv && !gmii_rx_er && (crc_nx != 32'hdebb20e3));
      end
   end
`else
   assign err_crc = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         dst        <= '0;
         dst_ok     <= 1'b0;
         m_data     <= '0;
         m_valid    <= 1'b0;
         m_last     <= 1'b0;
         src_mac    <= '0;
         frame_len  <= '0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         err_len    <= 1'b0;
         err_gmii   <= 1'b0;
         err_trunc  <= 1'b0;
      end else begin
         m_valid    <= 1'b0;
         m_last     <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         if (in_frame && !gmii_rx_dv) begin
            err_trunc  <= 1'b1;
            frame_done <= dst_ok;
            dst_ok     <= 1'b0;
            state      <= IDLE;
         end else if ((in_frame || state == WAIT_END) && gmii_rx_er) begin
            err_gmii <= 1'b1;
            state    <= DROP;
         end else begin
            case (state)
               IDLE: if (gmii_rx_dv && gmii_rxd == 8'h55) state <= PREAMBLE;
               PREAMBLE: begin
                  cnt   <= '0;
                  state <= !gmii_rx_dv ? IDLE : (gmii_rxd == 8'h55) ? PREAMBLE : (gmii_rxd == 8'hd5) ? DEST_MAC : DROP;
                  if (sfd) begin
                     err_len   <= 1'b0;
                     err_gmii  <= 1'b0;
                     err_trunc <= 1'b0;
                     dst_ok    <= 1'b0;
                  end
               end
               DEST_MAC: begin
                  dst <= dst_rx[39:0];
                  cnt <= (cnt == 11'd5) ? '0 : cnt_inc;
                  if (cnt == 11'd5) begin
                     dst_ok <= dst_hit;
                     state  <= dst_hit ? SRC_MAC : DROP;
                  end
               end
               SRC_MAC: begin
                  src_mac <= {src_mac[39:0], gmii_rxd};
                  cnt     <= (cnt == 11'd5) ? '0 : cnt_inc;
                  if (cnt == 11'd5) state <= LEN;
               end
               LEN: begin
                  if (cnt == 11'd0) begin
                     frame_len[15:8] <= gmii_rxd;
                     cnt             <= 11'd1;
                  end else begin
                     frame_len <= len_rx;
                     cnt       <= '0;
                     state     <= (len_rx == 16'd0 || len_rx > MAX_LEN) ? DROP : PAYLOAD;
                     if (len_rx == 16'd0 || len_rx > MAX_LEN) err_len <= 1'b1;
                  end
               end
               PAYLOAD: begin
                  m_valid <= 1'b1;
                  m_data  <= gmii_rxd;
                  m_last  <= cnt_inc == frame_len[10:0];
                  cnt     <= cnt_inc;
                  // short payloads keep counting through the pad up to the minimum size
                  if (cnt_inc == frame_len[10:0]) begin
                     state <= (cnt_inc < MIN_LEN) ? PAD : FCS;
                     cnt   <= (cnt_inc < MIN_LEN) ? cnt_inc : '0;
                  end
               end
               PAD: begin
                  cnt <= (cnt_inc == MIN_LEN) ? '0 : cnt_inc;
                  if (cnt_inc == MIN_LEN) state <= FCS;
               end
               FCS: begin
                  cnt <= (cnt == 11'd3) ? '0 : cnt_inc;
                  if (cnt == 11'd3) state <= WAIT_END;
               end
               WAIT_END: begin
                  if (!gmii_rx_dv) begin
                     frame_done <= 1'b1;
                     frame_ok   <= ~(err_crc | err_len | err_gmii | err_trunc);
                     dst_ok     <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     err_len <= 1'b1;
                  end
               end
               DROP: begin
                  if (!gmii_rx_dv) begin
                     frame_done <= dst_ok;
                     dst_ok     <= 1'b0;
                     state      <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ethernet_decapsulation.sv
// tb_ethernet_decapsulation: scenario tasks driving whole frames, compared against a frame-level model.
module tb_ethernet_decapsulation;
   localparam logic [47:0] LOCAL = 48'h023528fbdd66;
   localparam logic [47:0] BCAST = '1;
   localparam logic [47:0] SRC1  = 48'h072227acdb65;
`ifdef ETH_RX_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  gmii_rxd = '0;
   logic        gmii_rx_dv = 1'b0;
   logic        gmii_rx_er = 1'b0;
   logic [7:0]  m_data;
   logic        m_valid, m_last, frame_done, frame_ok;
   logic [47:0] src_mac;
   logic [15:0] frame_len;
   logic        err_crc, err_len, err_gmii, err_trunc;

   always #5 clk = ~clk;

   ethernet_decapsulation dut (
      .clk(clk), .rst(rst), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .src_mac(src_mac), .frame_len(frame_len),
      .frame_done(frame_done), .frame_ok(frame_ok), .err_crc(err_crc), .err_len(err_len),
      .err_gmii(err_gmii), .err_trunc(err_trunc)
   );

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   logic [7:0]  frm[$];
   logic [7:0]  pay[$];
   logic [7:0]  got[$];
   int          lasts[$];
   logic        d_ok[$];
   logic [3:0]  d_err[$];
   logic [47:0] d_src[$];
   logic [15:0] d_len[$];
   int          d_gap[$];

   // output monitor: collects beats and end-of-frame reports
   always @(negedge clk) begin
      cyc++;
      if (m_valid) begin
         got.push_back(m_data);
         if (m_last) begin
            lasts.push_back(got.size() - 1);
            last_cyc = cyc;
         end
      end
      if (frame_done) begin
         d_ok.push_back(frame_ok);
         d_err.push_back({err_crc, err_len, err_gmii, err_trunc});
         d_src.push_back(src_mac);
         d_len.push_back(frame_len);
         d_gap.push_back(cyc - last_cyc);
      end
   end

   task automatic clr();
      got.delete(); lasts.delete(); d_ok.delete(); d_err.delete(); d_src.delete(); d_len.delete(); d_gap.delete();
   endtask

   // frame as a transmitter would send it: preamble, SFD, header, payload, zero pad, FCS LSB first
   task automatic build(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] len);
      logic [31:0] c;
      c = '1;
      frm.delete();
      repeat (7) frm.push_back(8'h55);
      frm.push_back(8'hd5);
      for (int i = 5; i >= 0; i--) frm.push_back(da[8*i +: 8]);
      for (int i = 5; i >= 0; i--) frm.push_back(sa[8*i +: 8]);
      frm.push_back(len[15:8]);
      frm.push_back(len[7:0]);
      foreach (pay[i]) frm.push_back(pay[i]);
      for (int i = pay.size(); i < 46; i++) frm.push_back(8'h00);
      for (int i = 8; i < frm.size(); i++) begin
         c ^= {24'd0, frm[i]};
         repeat (8) c = c[0] ? (c >> 1) ^ 32'hedb88320 : c >> 1;
      end
      c = ~c;
      for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
   endtask

   task automatic drive(input int er_at, input int cut_at);
      for (int i = 0; i < frm.size() && i != cut_at; i++) begin
         @(negedge clk);
         gmii_rxd = frm[i]; gmii_rx_dv = 1'b1; gmii_rx_er = (i == er_at);
      end
      @(negedge clk);
      gmii_rxd = '0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
   endtask

   task automatic seq_pay(input int n);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'(i));
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if ({m_valid, m_last, frame_done, frame_ok, err_crc, err_len, err_gmii, err_trunc} !== 8'd0 || m_data !== 8'd0) begin
         fails++; $display("FAIL reset_flags: flags=%b data=%h, want all 0", {m_valid, m_last, frame_done, frame_ok, err_crc, err_len, err_gmii, err_trunc}, m_data);
      end
      tests++;
      if (src_mac !== 48'd0 || frame_len !== 16'd0) begin
         fails++; $display("FAIL reset_regs: src_mac=%h frame_len=%0d, want 0", src_mac, frame_len);
      end
   endtask

   task automatic test_basic();
      int bad = 0;
      clr(); seq_pay(46); build(LOCAL, SRC1, 16'd46); drive(-1, -1); repeat (6) @(negedge clk);
      foreach (pay[i]) if (i >= got.size() || got[i] !== pay[i]) bad++;
      tests++;
      if (got.size() != 46 || bad != 0) begin fails++; $display("FAIL t1_payload: %0d beats, %0d wrong; want 46 beats 00..2d", got.size(), bad); end
      tests++;
      if (lasts.size() != 1 || lasts[0] != 45) begin fails++; $display("FAIL t1_last: %0d m_last, first at %0d; want one at 45", lasts.size(), lasts.size() ? lasts[0] : -1); end
      tests++;
      if (d_ok.size() != 1 || d_ok[0] !== 1'b1 || d_err[0] !== 4'b0000) begin fails++; $display("FAIL t1_done: %0d done, ok=%b err=%b; want 1 done ok=1 err=0000", d_ok.size(), d_ok.size() ? d_ok[0] : 1'bx, d_err.size() ? d_err[0] : 4'bx); end
      tests++;
      if (d_src.size() != 1 || d_src[0] !== SRC1 || d_len[0] !== 16'd46) begin fails++; $display("FAIL t1_hdr: src=%h len=%0d; want %h 46", d_src.size() ? d_src[0] : 48'bx, d_len.size() ? d_len[0] : 16'bx, SRC1); end
      tests++;
      if (d_gap.size() != 1 || d_gap[0] < 5) begin fails++; $display("FAIL t1_gap: done %0d cycles after m_last; want >=5", d_gap.size() ? d_gap[0] : -1); end
   endtask

   task automatic test_pad();
      int bad = 0;
      clr(); pay.delete(); repeat (10) pay.push_back(8'($urandom()));
      build(LOCAL, SRC1, 16'd10); drive(-1, -1); repeat (6) @(negedge clk);
      foreach (pay[i]) if (i >= got.size() || got[i] !== pay[i]) bad++;
      tests++;
      if (got.size() != 10 || bad != 0) begin fails++; $display("FAIL t2_payload: %0d beats, %0d wrong; want 10", got.size(), bad); end
      tests++;
      if (lasts.size() != 1 || lasts[0] != 9 || d_ok.size() != 1 || d_ok[0] !== 1'b1) begin fails++; $display("FAIL t2_end: %0d m_last, %0d done; want last at 9 and one ok done", lasts.size(), d_ok.size()); end
      tests++;
      if (d_gap.size() != 1 || d_gap[0] < 5) begin fails++; $display("FAIL t2_gap: gap %0d; want >=5", d_gap.size() ? d_gap[0] : -1); end
   endtask

   task automatic test_crc();
      logic [3:0] exp_err;
      exp_err = CRC_EN ? 4'b1000 : 4'b0000;
      clr(); seq_pay(46); build(LOCAL, SRC1, 16'd46);
      frm[8 + 14 + 5] = frm[8 + 14 + 5] ^ 8'h01;
      drive(-1, -1); repeat (6) @(negedge clk);
      tests++;
      if (got.size() != 46 || got[5] !== 8'h04) begin fails++; $display("FAIL t3_payload: %0d beats, byte5=%h; want 46, 04", got.size(), got.size() > 5 ? got[5] : 8'bx); end
      tests++;
      if (d_ok.size() != 1 || d_ok[0] !== ~CRC_EN || d_err[0] !== exp_err) begin fails++; $display("FAIL t3_done: %0d done ok=%b err=%b; want 1 ok=%b err=%b", d_ok.size(), d_ok.size() ? d_ok[0] : 1'bx, d_err.size() ? d_err[0] : 4'bx, ~CRC_EN, exp_err); end
   endtask

   task automatic test_filter();
      clr(); seq_pay(46); build(48'h020000000001, SRC1, 16'd46); drive(-1, -1); repeat (6) @(negedge clk);
      tests++;
      if (got.size() != 0 || d_ok.size() != 0) begin fails++; $display("FAIL t4_foreign: %0d beats %0d done; want 0 0", got.size(), d_ok.size()); end
      clr(); build(BCAST, SRC1, 16'd46); drive(-1, -1); repeat (6) @(negedge clk);
      tests++;
      if (got.size() != 46 || d_ok.size() != 1 || d_ok[0] !== 1'b1) begin fails++; $display("FAIL t4_bcast: %0d beats %0d done; want 46 beats, ok done", got.size(), d_ok.size()); end
   endtask

   task automatic test_gmii_err();
      int bad = 0;
      clr(); seq_pay(46); build(LOCAL, SRC1, 16'd46); drive(8 + 14 + 20, -1); repeat (6) @(negedge clk);
      for (int i = 0; i < 20; i++) if (i >= got.size() || got[i] !== pay[i]) bad++;
      tests++;
      if (got.size() != 20 || bad != 0 || lasts.size() != 0) begin fails++; $display("FAIL t5_payload: %0d beats %0d wrong %0d last; want 20 0 0", got.size(), bad, lasts.size()); end
      tests++;
      if (d_ok.size() != 1 || d_ok[0] !== 1'b0 || d_err[0] !== 4'b0010) begin fails++; $display("FAIL t5_done: %0d done err=%b; want 1 done ok=0 err=0010", d_ok.size(), d_err.size() ? d_err[0] : 4'bx); end
   endtask

   task automatic test_reset_mid();
      clr(); seq_pay(46); build(LOCAL, SRC1, 16'd46);
      for (int i = 0; i < 8 + 14 + 10; i++) begin
         @(negedge clk); gmii_rxd = frm[i]; gmii_rx_dv = 1'b1;
      end
      @(negedge clk); rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = '0;
      @(negedge clk);
      tests++;
      if ({m_valid, m_last, frame_done, frame_ok, err_crc, err_len, err_gmii, err_trunc} !== 8'd0 || src_mac !== 48'd0 || frame_len !== 16'd0 || m_data !== 8'd0) begin
         fails++; $display("FAIL t6_rst_outputs: flags=%b src=%h len=%0d; want 0", {m_valid, m_last, frame_done, frame_ok, err_crc, err_len, err_gmii, err_trunc}, src_mac, frame_len);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      tests++;
      if (got.size() != 10 || d_ok.size() != 0) begin fails++; $display("FAIL t6_abort: %0d beats %0d done; want 10 0", got.size(), d_ok.size()); end
      clr(); drive(-1, -1); repeat (6) @(negedge clk);
      tests++;
      if (got.size() != 46 || d_ok.size() != 1 || d_ok[0] !== 1'b1 || d_src[0] !== SRC1) begin fails++; $display("FAIL t6_next: %0d beats %0d done; want 46 beats, ok done", got.size(), d_ok.size()); end
   endtask

   task automatic test_len_err();
      logic [15:0] bad_len[2];
      bad_len[0] = 16'd0; bad_len[1] = 16'd1501;
      foreach (bad_len[k]) begin
         clr(); seq_pay(20); build(LOCAL, SRC1, bad_len[k]); drive(-1, -1); repeat (6) @(negedge clk);
         tests++;
         if (got.size() != 0 || d_ok.size() != 1 || d_ok[0] !== 1'b0 || d_err[0] !== 4'b0100 || d_len[0] !== bad_len[k]) begin
            fails++; $display("FAIL len_err_%0d: %0d beats %0d done err=%b; want 0 beats, 1 done err=0100", bad_len[k], got.size(), d_ok.size(), d_err.size() ? d_err[0] : 4'bx);
         end
      end
   endtask

   task automatic test_trunc();
      clr(); seq_pay(46); build(LOCAL, SRC1, 16'd46); drive(-1, 8 + 14 + 30); repeat (6) @(negedge clk);
      tests++;
      if (got.size() != 30 || lasts.size() != 0 || d_ok.size() != 1 || d_ok[0] !== 1'b0 || d_err[0] !== 4'b0001) begin
         fails++; $display("FAIL trunc: %0d beats %0d last %0d done err=%b; want 30 0 1 0001", got.size(), lasts.size(), d_ok.size(), d_err.size() ? d_err[0] : 4'bx);
      end
      clr(); build(LOCAL, SRC1, 16'd46); frm.push_back(8'hab); drive(-1, -1); repeat (6) @(negedge clk);
      tests++;
      if (got.size() != 46 || d_ok.size() != 1 || d_ok[0] !== 1'b0 || d_err[0] !== 4'b0100) begin
         fails++; $display("FAIL extra_byte: %0d beats %0d done err=%b; want 46 1 0100", got.size(), d_ok.size(), d_err.size() ? d_err[0] : 4'bx);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  exp[$];
      int          exp_last[$];
      logic [47:0] exp_src[$];
      logic [15:0] exp_len[$];
      logic [47:0] da, sa;
      int          len, kind;
      int          bad = 0;
      clr();
      for (int f = 0; f < 12; f++) begin
         len  = $urandom_range(1, 80);
         kind = $urandom_range(0, 2);
         da   = (kind == 0) ? LOCAL : (kind == 1) ? BCAST : {16'h0200, 32'($urandom())};
         sa   = {16'($urandom()), 32'($urandom())};
         pay.delete();
         repeat (len) pay.push_back(8'($urandom()));
         build(da, sa, 16'(len));
         if (kind != 2) begin
            foreach (pay[i]) exp.push_back(pay[i]);
            exp_last.push_back(exp.size() - 1);
            exp_src.push_back(sa);
            exp_len.push_back(16'(len));
         end
         drive(-1, -1);
      end
      repeat (6) @(negedge clk);
      foreach (exp[i]) if (i >= got.size() || got[i] !== exp[i]) bad++;
      tests++;
      if (got.size() != exp.size() || bad != 0) begin fails++; $display("FAIL b2b_payload: %0d beats (%0d wrong); want %0d", got.size(), bad, exp.size()); end
      bad = 0;
      foreach (exp_last[i]) if (i >= lasts.size() || lasts[i] != exp_last[i]) bad++;
      tests++;
      if (lasts.size() != exp_last.size() || bad != 0) begin fails++; $display("FAIL b2b_last: %0d m_last (%0d misplaced); want %0d", lasts.size(), bad, exp_last.size()); end
      bad = 0;
      foreach (exp_src[i]) if (i >= d_src.size() || d_src[i] !== exp_src[i] || d_len[i] !== exp_len[i] || d_ok[i] !== 1'b1) bad++;
      tests++;
      if (d_src.size() != exp_src.size() || bad != 0) begin fails++; $display("FAIL b2b_done: %0d done (%0d wrong); want %0d good", d_src.size(), bad, exp_src.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pad();
      test_crc();
      test_filter();
      test_gmii_err();
      test_reset_mid();
      test_len_err();
      test_trunc();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
